// File: rtl/cpu_types_pkg.sv
// Shared CPU types and constants used by the fetch stage.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-word reads, buffers one
// word while decode is stalled, and drives the IF-side inputs of IF/ID.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] ifinstr,
  output logic [31:0] ifJALjump_addr,
  output logic        ifW
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        hold_instr_q, hold_instr_d;
  word_t        hold_npc_q, hold_npc_d;

  word_t pc_plus4_c;
  word_t redirect_tgt_c;
  logic  unused_redirect_lsb;

  assign pc_plus4_c          = pc_q + PC_STEP;
  assign redirect_tgt_c      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign iaddr               = pc_q;

  // State register; reset discards any pending wait or held word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      hold_instr_q <= NOP_INSTR;
      hold_npc_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_npc_q   <= hold_npc_d;
    end
  end

  // Next state and IF/ID outputs; priority is halt > redirect > stall/ihit.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_instr_d   = hold_instr_q;
    hold_npc_d     = hold_npc_q;
    iREN           = 1'b0;
    ifW            = 1'b0;
    ifinstr        = NOP_INSTR;
    ifJALjump_addr = 32'h0;

    case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          pc_d = redirect_tgt_c;
          ifW  = 1'b1;
        end else if (ihit) begin
          if (!stall) begin
            ifinstr        = iload;
            ifJALjump_addr = pc_plus4_c;
            ifW            = 1'b1;
            pc_d           = pc_plus4_c;
          end else begin
            hold_instr_d = iload;
            hold_npc_d   = pc_plus4_c;
            state_d      = HOLD;
          end
        end else begin
          // No data yet: bubble when decode can take it, otherwise hold IF/ID.
          ifW = !stall;
        end
      end

      HOLD: begin
        ifinstr        = hold_instr_q;
        ifJALjump_addr = hold_npc_q;
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          ifinstr        = NOP_INSTR;
          ifJALjump_addr = 32'h0;
          ifW            = 1'b1;
          pc_d           = redirect_tgt_c;
          state_d        = FETCH;
        end else if (!stall) begin
          ifW     = 1'b1;
          pc_d    = hold_npc_q;
          state_d = FETCH;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (!nRST) begin
      iREN           = 1'b0;
      ifW            = 1'b0;
      ifinstr        = NOP_INSTR;
      ifJALjump_addr = 32'h0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a queue-based model.
module tb_fetch_stage;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] ifinstr;
  logic [31:0] ifJALjump_addr;
  logic        ifW;

  int total;
  int bad;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .iload          (iload),
    .iREN           (iREN),
    .iaddr          (iaddr),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ifinstr        (ifinstr),
    .ifJALjump_addr (ifJALjump_addr),
    .ifW            (ifW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: PC, an optional one-entry buffer of fetched-but-unwritten
  // words, and a sticky halted flag.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  logic [31:0] m_pc;
  ent_t        m_buf[$];
  bit          m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases after an edge.
  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_ifW", 32'(ifW), 32'd0);
    chk("rst_ifinstr", ifinstr, 32'h0);
    chk("rst_jal", ifJALjump_addr, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    m_pc     = 32'h0;
    m_halted = 1'b0;
    m_buf.delete();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // One clock: drive inputs, check outputs at mid-cycle, advance the model.
  task automatic step(input bit h, input logic [31:0] ld, input bit st,
                      input bit rd, input logic [31:0] rpc, input bit hl);
    bit          e_ren;
    bit          e_w;
    logic [31:0] e_instr;
    logic [31:0] e_jal;
    logic [31:0] tgt;
    ihit = h; iload = ld; stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
    tgt     = rpc & 32'hFFFF_FFFC;
    e_ren   = 1'b0;
    e_w     = 1'b0;
    e_instr = 32'h0;
    e_jal   = 32'h0;
    #4;
    chk("iaddr", iaddr, m_pc);
    if (m_halted) begin
      chk("halted_instr", ifinstr, 32'h0);
    end else if (m_buf.size() > 0) begin
      e_instr = m_buf[0].instr;
      e_jal   = m_buf[0].npc;
      if (hl) begin
        m_halted = 1'b1;
      end else if (rd) begin
        e_w = 1'b1; e_instr = 32'h0; e_jal = 32'h0;
        m_pc = tgt;
        m_buf.delete();
      end else if (!st) begin
        e_w  = 1'b1;
        m_pc = m_buf[0].npc;
        m_buf.delete();
      end
    end else begin
      e_ren = 1'b1;
      if (hl) begin
        m_halted = 1'b1;
        chk("halt_instr", ifinstr, 32'h0);
      end else if (rd) begin
        e_w  = 1'b1;
        m_pc = tgt;
      end else if (h && !st) begin
        e_w = 1'b1; e_instr = ld; e_jal = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end else if (h) begin
        m_buf.push_back('{instr: ld, npc: m_pc + 32'd4});
      end else begin
        e_w = !st;
      end
    end
    chk("iREN", 32'(iREN), 32'(e_ren));
    chk("ifW", 32'(ifW), 32'(e_w));
    if (e_w) begin
      chk("ifinstr", ifinstr, e_instr);
      chk("jal", ifJALjump_addr, e_jal);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int halted_cycles;
    total = 0;
    bad   = 0;
    nRST = 1'b1; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    #2;
    do_reset();

    // Back-to-back hits.
    step(1, 32'h11, 0, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0, 0);
    step(1, 32'h33, 0, 0, 0, 0);
    chk("b2b_iaddr", iaddr, 32'hC);
    step(1, 32'h44, 0, 0, 0, 0);

    // Memory wait at 0x10 then hit.
    step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    step(1, 32'hAABB, 0, 0, 0, 0);
    chk("wait_iaddr", iaddr, 32'h14);

    // Stalled hit at 0x20 held for three cycles.
    step(1, 32'h14, 0, 0, 0, 0);
    step(1, 32'h18, 0, 0, 0, 0);
    step(1, 32'h1C, 0, 0, 0, 0);
    chk("pre_hold_iaddr", iaddr, 32'h20);
    step(1, 32'h1234, 1, 0, 0, 0);
    step(1, 32'hDEAD, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    chk("hold_release_iaddr", iaddr, 32'h24);

    // Redirect out of HOLD with a coincident hit.
    step(1, 32'h5555, 1, 0, 0, 0);
    step(1, 32'h6666, 0, 1, 32'h103, 0);
    chk("redir_iaddr", iaddr, 32'h100);

    // Halt wins over redirect and hit, then everything is ignored.
    step(0, 32'h0, 0, 1, 32'h40, 0);
    step(1, 32'h7777, 0, 1, 32'h200, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    end
    chk("halt_iaddr", iaddr, 32'h40);

    // Async reset mid-HOLD, then PC wrap.
    do_reset();
    step(1, 32'h99, 1, 0, 0, 0);
    do_reset();
    step(0, 32'h0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap_pre_iaddr", iaddr, 32'hFFFF_FFFC);
    step(1, 32'hCAFE, 0, 0, 0, 0);
    chk("wrap_iaddr", iaddr, 32'h0);

    // Randomized traffic with occasional halts recovered by reset.
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 59) == 0);
      if (m_halted) halted_cycles++;
      if (halted_cycles > 3) begin
        halted_cycles = 0;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that produces the IF-side inputs of the IF/ID pipeline register: `ifinstr`, `ifJALjump_addr` and the write enable `ifW`.
- Owns the PC and issues single-word instruction-memory reads with a request/`ihit` handshake.
- Buffers one instruction when decode is stalled.
- Injects NOP bubbles on memory wait and on control redirects.
- Freezes permanently on halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction memory returns valid data this cycle.
- iload  in  32  instruction word from memory; valid when ihit=1.
- iREN  out  1  instruction read request.
- iaddr  out  32  instruction read address (= PC).
- stall  in  1  hazard unit: IF/ID must hold its contents.
- redirect  in  1  branch/jump taken; flush IF and load new PC.
- redirect_pc  in  32  redirect target; bits [1:0] ignored, forced 00.
- halt  in  1  halt seen downstream; sticky stop.
- ifinstr  out  32  instruction presented to IF/ID.
- ifJALjump_addr  out  32  PC+4 of presented instruction (JAL link value).
- ifW  out  1  IF/ID write enable.

Behaviour:
- Clock and reset: CLK and nRST as listed in Ports (reset nRST, asynchronous, active-low; clock CLK).
- State: `pc` (32), `hold_instr` (32), `hold_npc` (32), `fsm` ∈ {FETCH, HOLD, HALTED}.
- Reset (async, while nRST=0):
  - pc=PC_INIT, hold regs=0, fsm=FETCH.
  - Outputs: iREN=0, ifW=0, ifinstr=0, ifJALjump_addr=0, iaddr=PC_INIT.
  - Reset mid-wait or mid-HOLD discards everything.
- Outputs are combinational from state and inputs; all register updates occur on the CLK rising edge.
- iaddr = pc in all states. pc+4 wraps modulo 2^32.
- Priority in FETCH and HOLD: halt > redirect > stall/ihit.
- FETCH (iREN=1):
  - halt: ifW=0, ifinstr=0; → HALTED; pc unchanged.
  - redirect: pc ← {redirect_pc[31:2],2'b00}; bubble ifW=1, ifinstr=0, ifJALjump_addr=0. Any ihit this cycle is discarded; stay FETCH.
  - ihit & !stall: ifinstr=iload, ifJALjump_addr=pc+4, ifW=1; pc ← pc+4.
  - ihit & stall: ifW=0; hold_instr ← iload, hold_npc ← pc+4; → HOLD.
  - !ihit: ifinstr=0, ifJALjump_addr=0, ifW=!stall (bubble when decode is free, hold when stalled); pc unchanged.
- HOLD (iREN=0, ifinstr=hold_instr, ifJALjump_addr=hold_npc):
  - halt: ifW=0; → HALTED.
  - redirect: pc ← redirect target; ifW=1 with ifinstr=0, ifJALjump_addr=0 (overrides hold values); → FETCH.
  - !stall: ifW=1; pc ← hold_npc; → FETCH.
  - stall: ifW=0; stay.
- HALTED: iREN=0, ifW=0, ifinstr=0, ifJALjump_addr=0; all inputs ignored until nRST.
- Latency:
  - Instruction appears on ifinstr in the same cycle as ihit (FETCH) or the first unstalled cycle (HOLD).
  - First request is issued on the first cycle after reset deasserts.
  - Back-to-back fetches with ihit=1 every cycle yield one instruction per cycle.
- Each fetched word is written to IF/ID exactly once or discarded by redirect/halt; it is never duplicated.

Decomposition:
- cpu_types_pkg:
  - word_t (32-bit)
  - fetch_state_t enum {FETCH, HOLD, HALTED}
  - constant NOP_INSTR = 32'h0
  - constant PC_STEP = 4
- Single module, no sub-module. The hold buffer is two registers and does not justify its own block.

Test Plan:
- Reset, PC_INIT=0, ihit=1 every cycle, iload=0x11,0x22,0x33 -> ifW=1 each cycle; iaddr 0,4,8; ifJALjump_addr 4,8,12.
- ihit low 2 cycles at pc=0x10, then ihit with iload=0xAABB, stall=0 -> two bubbles (ifW=1, ifinstr=0), then ifinstr=0xAABB, ifJALjump_addr=0x14.
- ihit with iload=0x1234 at pc=0x20 while stall=1 for 3 cycles -> iREN=0 during hold; ifW=0; on release ifinstr=0x1234, ifW=1; next iaddr=0x24.
- redirect=1, redirect_pc=0x103 during HOLD with simultaneous ihit -> bubble (ifW=1, ifinstr=0); next iaddr=0x100; held word never written.
- halt=1 together with redirect and ihit at pc=0x40 -> ifW=0 that cycle; next cycles iREN=0, ifW=0, iaddr stays 0x40 regardless of inputs.
- nRST asserted mid-HOLD, then pc=0xFFFFFFFC fetch after redirect -> outputs zero asynchronously and pc=PC_INIT; wrap case gives ifJALjump_addr=0x0.
